// File: rtl/dec_rkey_conv.sv
// Decryption round-key converter: buffers NR+1 forward round keys, applies InvMixColumns to
// keys 1..NR-1 one column per cycle, then streams the set out in reverse order.
module dec_rkey_conv #(
  parameter int unsigned NR = 10
) (
  input  logic         i_Clk,
  input  logic         i_Rstn,
  input  logic         i_KeyVld,
  input  logic [127:0] i_Key,
  output logic         o_KeyRdy,
  output logic         o_RKVld,
  output logic [127:0] o_RK,
  output logic [3:0]   o_RKIdx,
  input  logic         i_RKRdy,
  output logic         o_Busy
);

  localparam logic [3:0] NrW = 4'(NR);

  typedef enum logic [1:0] {StLoad, StConv, StDrain} state_e;

  state_e         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [1:0]     ccnt_q, ccnt_d;
  logic [3:0]     rptr_q, rptr_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   rk_mem_q [NR+1];

  logic           mem_we;
  logic           col_we;
  logic [31:0]    col_in;
  logic [31:0]    col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e built from x2/x4/x8 xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = c[31-8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    col_in = work_q[127:96];
    unique case (ccnt_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  assign col_out = inv_mix_col(col_in);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ccnt_d  = ccnt_q;
    rptr_d  = rptr_q;
    work_d  = work_q;
    mem_we  = 1'b0;
    col_we  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (i_KeyVld) begin
          if (wcnt_q == 4'd0) begin
            mem_we = 1'b1;
            wcnt_d = wcnt_q + 4'd1;
          end else if (wcnt_q == NrW) begin
            mem_we  = 1'b1;
            rptr_d  = NrW;
            state_d = StDrain;
          end else begin
            work_d  = i_Key;
            ccnt_d  = 2'd0;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        col_we = 1'b1;
        ccnt_d = ccnt_q + 2'd1;
        if (ccnt_q == 2'd3) begin
          wcnt_d  = wcnt_q + 4'd1;
          state_d = StLoad;
        end
      end
      StDrain: begin
        if (i_RKRdy) begin
          if (rptr_q == 4'd0) begin
            wcnt_d  = 4'd0;
            state_d = StLoad;
          end else begin
            rptr_d = rptr_q - 4'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q <= StLoad;
      wcnt_q  <= 4'd0;
      ccnt_q  <= 2'd0;
      rptr_q  <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ccnt_q  <= ccnt_d;
      rptr_q  <= rptr_d;
      work_q  <= work_d;
    end
  end

  // Key storage needs no reset; contents are only read after a full set is written.
  always_ff @(posedge i_Clk) begin
    if (mem_we) begin
      rk_mem_q[wcnt_q] <= i_Key;
    end
    if (col_we) begin
      unique case (ccnt_q)
        2'd0: rk_mem_q[wcnt_q][127:96] <= col_out;
        2'd1: rk_mem_q[wcnt_q][95:64]  <= col_out;
        2'd2: rk_mem_q[wcnt_q][63:32]  <= col_out;
        2'd3: rk_mem_q[wcnt_q][31:0]   <= col_out;
        default: ;
      endcase
    end
  end

  assign o_KeyRdy = (state_q == StLoad);
  assign o_RKVld  = (state_q == StDrain);
  assign o_RK     = o_RKVld ? rk_mem_q[rptr_q] : '0;
  assign o_RKIdx  = rptr_q;
  assign o_Busy   = (state_q != StLoad) || (wcnt_q != 4'd0);

endmodule

// File: tb/tb_dec_rkey_conv.sv
// Directed bench for dec_rkey_conv: table-driven key sets plus hand-written timing sequences.
module tb_dec_rkey_conv;

  localparam logic [127:0] K8E  = {4{32'h8e4da1bc}};
  localparam logic [127:0] KDB  = {4{32'hdb135345}};
  localparam logic [127:0] K01  = {4{32'h01010101}};
  localparam logic [127:0] KC6  = {4{32'hc6c6c6c6}};
  localparam logic [127:0] KONE = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_KeyVld;
  logic [127:0] i_Key;
  logic         o_KeyRdy;
  logic         o_RKVld;
  logic [127:0] o_RK;
  logic [3:0]   o_RKIdx;
  logic         i_RKRdy;
  logic         o_Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t cur [11];

  dec_rkey_conv #(.NR(10)) dut (
    .i_Clk    (clk),
    .i_Rstn   (rst_n),
    .i_KeyVld (i_KeyVld),
    .i_Key    (i_Key),
    .o_KeyRdy (o_KeyRdy),
    .o_RKVld  (o_RKVld),
    .o_RK     (o_RK),
    .o_RKIdx  (o_RKIdx),
    .i_RKRdy  (i_RKRdy),
    .o_Busy   (o_Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_base(input logic [127:0] k0, input logic [127:0] kmid,
                           input logic [127:0] emid, input logic [127:0] k10);
    cur[0] = '{key: k0, exp: k0};
    for (int i = 1; i < 10; i++) cur[i] = '{key: kmid, exp: emid};
    cur[10] = '{key: k10, exp: k10};
  endtask

  task automatic send_key(input logic [127:0] k);
    int n;
    i_KeyVld = 1'b1;
    i_Key    = k;
    n = 0;
    while (!o_KeyRdy && n < 20) begin
      tick();
      n++;
    end
    check("key_rdy_wait", {127'b0, o_KeyRdy}, 128'd1);
    tick();
    i_KeyVld = 1'b0;
  endtask

  task automatic load_set(input bit timing_k1);
    for (int i = 0; i < 11; i++) begin
      if (timing_k1 && i == 1) begin
        i_KeyVld = 1'b1;
        i_Key    = cur[1].key;
        check("k1_rdy", {127'b0, o_KeyRdy}, 128'd1);
        tick();
        check("conv_busy", {127'b0, o_Busy}, 128'd1);
        for (int s = 0; s < 4; s++) begin
          check("conv_rdy_low", {127'b0, o_KeyRdy}, 128'd0);
          tick();
        end
        check("conv_rdy_back", {127'b0, o_KeyRdy}, 128'd1);
      end else begin
        send_key(cur[i].key);
      end
    end
  endtask

  task automatic drain_set(input int stall_idx);
    int n;
    i_RKRdy = 1'b1;
    for (int e = 10; e >= 0; e--) begin
      n = 0;
      while (!o_RKVld && n < 40) begin
        tick();
        n++;
      end
      check("drain_vld", {127'b0, o_RKVld}, 128'd1);
      check("drain_idx", {124'b0, o_RKIdx}, 128'(e));
      check("drain_rk", o_RK, cur[e].exp);
      if (e == stall_idx) begin
        i_RKRdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_idx", {124'b0, o_RKIdx}, 128'(e));
          check("stall_rk", o_RK, cur[e].exp);
        end
        i_RKRdy = 1'b1;
      end
      tick();
    end
    check("post_drain_vld", {127'b0, o_RKVld}, 128'd0);
    check("post_drain_rk", o_RK, 128'd0);
    check("post_drain_rdy", {127'b0, o_KeyRdy}, 128'd1);
    i_RKRdy = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    i_KeyVld = 1'b0;
    i_Key    = '0;
    i_RKRdy  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_KeyVld = 1'($urandom);
      i_Key    = {$urandom, $urandom, $urandom, $urandom};
      i_RKRdy  = 1'($urandom);
      tick();
    end
    check("rst_keyrdy", {127'b0, o_KeyRdy}, 128'd1);
    check("rst_rkvld", {127'b0, o_RKVld}, 128'd0);
    check("rst_rk", o_RK, 128'd0);
    check("rst_idx", {124'b0, o_RKIdx}, 128'd0);
    check("rst_busy", {127'b0, o_Busy}, 128'd0);
    i_KeyVld = 1'b0;
    i_Key    = '0;
    i_RKRdy  = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Reference set with CONV timing on k1 and a 5-cycle stall at idx 7.
    fill_base('0, K8E, KDB, KONE);
    load_set(1'b1);
    drain_set(7);

    // Fixed-point columns at idx 5 and 6, then a back-to-back second set.
    fill_base({4{32'h01234567}}, K8E, KDB, {4{32'h89abcdef}});
    cur[5] = '{key: K01, exp: K01};
    cur[6] = '{key: KC6, exp: KC6};
    load_set(1'b0);
    drain_set(-1);
    fill_base(K8E, KC6, KC6, K01);
    cur[2] = '{key: K8E, exp: KDB};
    load_set(1'b0);
    drain_set(-1);

    // Reset on the 2nd CONV cycle of k4, then a fresh set.
    fill_base(KONE, K01, K01, KONE);
    for (int i = 0; i < 5; i++) send_key(cur[i].key);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_keyrdy", {127'b0, o_KeyRdy}, 128'd1);
    check("midrst_busy", {127'b0, o_Busy}, 128'd0);
    check("midrst_rkvld", {127'b0, o_RKVld}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fill_base('0, K8E, KDB, {4{32'h5a5aa5a5}});
    cur[4] = '{key: KC6, exp: KC6};
    load_set(1'b0);
    drain_set(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_rkey_conv.md
# dec_rkey_conv

Decryption round-key converter for the equivalent inverse cipher. It accepts the NR+1 forward-order round keys from the encryption key schedule and applies InvMixColumns to keys 1..NR-1, one 32-bit column per cycle. It stores all keys in an internal buffer, then streams them out in decryption order (key NR first, key 0 last) to the inverse-round datapath. It sits between the key expansion unit and the AES decryption core.

## Interface
- NR, 10, number of cipher rounds; legal values 10, 12, 14; buffer depth NR+1.
- i_Clk  in  1  clock, rising edge.
- i_Rstn  in  1  asynchronous active-low reset.
- i_KeyVld  in  1  input round key valid.
- i_Key  in  128  forward-order round key; bits [127:96] are column 0, byte [127:120] is row 0.
- o_KeyRdy  out  1  converter can accept a key this cycle.
- o_RKVld  out  1  output round key valid.
- o_RK  out  128  decryption round key; forced to 0 when o_RKVld=0.
- o_RKIdx  out  4  forward index of the key on o_RK (NR..0).
- i_RKRdy  in  1  consumer accepts o_RK this cycle.
- o_Busy  out  1  high in CONV or DRAIN, or in LOAD with at least one key held.

## Operation
- States: LOAD (reset state), CONV, DRAIN.
- Input handshake: a key is accepted when i_KeyVld & o_KeyRdy. o_KeyRdy is 1 only in LOAD and is decoded combinationally from state.
- Input counter wcnt, 0..NR, counts accepted keys and gives the forward index of the key being accepted.
- LOAD, key accepted with wcnt=0:
  - store the key unchanged in buf[0]; stay in LOAD.
- LOAD, key accepted with 1 ≤ wcnt ≤ NR-1:
  - latch the key into the working register; go to CONV with column counter ccnt=0.
- LOAD, key accepted with wcnt=NR:
  - store the key unchanged in buf[NR]; go to DRAIN with rptr=NR.
- CONV, one column per cycle, ccnt=0..3:
  - column ccnt (ccnt=0 is bits [127:96]) passes through the single InvMixColumns column unit; the result is written into that column of buf[wcnt].
  - after ccnt=3, increment wcnt and return to LOAD.
- InvMixColumns column, input bytes a0..a3 (a0 = MSB byte):
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3; o1, o2 and o3 use the same coefficients rotated right by one position per row.
  - Multiplication is in GF(2^8) with reduction polynomial 0x11B.
  - Implemented with xtime chains only: no tables, no multipliers.
- DRAIN:
  - o_RKVld=1, o_RK=buf[rptr], o_RKIdx=rptr.
  - On i_RKRdy, decrement rptr; the handshake at rptr=0 returns the block to LOAD with wcnt=0.
  - With i_RKRdy=0, o_RK and o_RKIdx hold stable.
- i_KeyVld is ignored outside LOAD. i_RKRdy is ignored outside DRAIN.

## Timing
- Reset values: state LOAD, wcnt=0, ccnt=0, rptr=0, o_KeyRdy=1, o_RKVld=0, o_RK=0, o_RKIdx=0, o_Busy=0. Buffer contents are don't-care.
- Reset mid-operation (CONV or DRAIN) abandons the set immediately. After release the block is in LOAD with wcnt=0 and o_KeyRdy=1.
- Key 0 accepted at cycle t: o_KeyRdy stays 1 at t+1.
- Key i (1..NR-1) accepted at cycle t: CONV at t+1..t+4, one column written per cycle; o_KeyRdy=0 at t+1..t+4 and 1 again at t+5.
- Key NR accepted at cycle t: o_RKVld=1 with o_RKIdx=NR at t+1.
- Minimum load time for NR=10 is 11 accepts + 36 CONV cycles = 47 cycles. Drain takes 11 cycles with i_RKRdy held high.
- Last output handshake (idx 0) at cycle t: o_RKVld=0 and o_KeyRdy=1 at t+1. A new key may be accepted at t+1 with no bubble.

## Test plan
- Reset: hold i_Rstn=0 with random inputs -> o_KeyRdy=1, o_RKVld=0, o_RK=0, o_RKIdx=0, o_Busy=0.
- Full set, NR=10, i_RKRdy=1, input keys:
  - k0=0, k1..k9={4{32'h8e4da1bc}}, k10=all 1s.
  - Required output in order: idx10=all 1s; idx9..1={4{32'hdb135345}}; idx0=0.
  - Also, for k5={4{32'h01010101}}, idx5={4{32'h01010101}}; for k5={4{32'hc6c6c6c6}}, idx5 is unchanged.
- CONV timing: accept k1 at cycle t -> o_KeyRdy=0 at t+1..t+4 and 1 at t+5. i_KeyVld held high throughout causes no extra accept.
- Output backpressure: during DRAIN hold i_RKRdy=0 for 5 cycles at idx 7 -> o_RK and o_RKIdx=7 stable, no skipped or repeated key after release.
- Reset at the 2nd CONV cycle of k4, then a full new set -> the output set matches the new keys only; idx sequence is 10..0.
- Back-to-back sets: idx0 handshake at t, key 0 of the next set offered at t+1 -> accepted at t+1; the second set drains correctly.
